// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter that steers the winner's 1-bit data onto a shared channel.
// A grant is held until the owner drops its request or has held the channel for MAX_HOLD cycles.
module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] x,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [2:0] HOLD_LAST = 3'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  gnt_q, gnt_d;
  logic        valid_q, valid_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [2:0]  hold_cnt_q, hold_cnt_d;

  logic        releaseNow;
  logic [1:0]  arbBase;
  logic [1:0]  winner;

  // First requester at or after base in circular order; scanning from the far end
  // lets the nearest hit overwrite any later one.
  function automatic logic [1:0] pickWinner(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] w;
    logic [1:0] idx;
    w = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign releaseNow = (state_q == GRANT) && (!req[sel_q] || (hold_cnt_q == HOLD_LAST));
  assign arbBase    = releaseNow ? (sel_q + 2'd1) : ptr_q;
  assign winner     = pickWinner(req, arbBase);

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    gnt_d      = gnt_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = GRANT;
          sel_d      = winner;
          gnt_d      = 4'b0001 << winner;
          valid_d    = 1'b1;
          hold_cnt_d = 3'd0;
        end else begin
          valid_d = 1'b0;
          gnt_d   = 4'b0000;
        end
      end
      GRANT: begin
        if (releaseNow) begin
          // Re-arbitrate in the same edge so a waiting requester sees no idle bubble.
          ptr_d      = sel_q + 2'd1;
          hold_cnt_d = 3'd0;
          if (|req) begin
            state_d = GRANT;
            sel_d   = winner;
            gnt_d   = 4'b0001 << winner;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= 2'd0;
      gnt_q      <= 4'b0000;
      valid_q    <= 1'b0;
      ptr_q      <= 2'd0;
      hold_cnt_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign y     = valid_q & x[sel_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: one instance with MAX_HOLD=4 and one with MAX_HOLD=2,
// sharing clock and reset, each with its own request/data inputs.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req4, x4, req2, x2;
  logic [3:0] gnt4, gnt2;
  logic [1:0] sel4, sel2;
  logic       valid4, valid2, y4, y2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut4 (
    .clk(clk), .rst(rst), .req(req4), .x(x4),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .y(y4)
  );

  mux4_rr_arbiter #(.MAX_HOLD(2)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .x(x2),
    .gnt(gnt2), .sel(sel2), .valid(valid2), .y(y2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r4, input logic [3:0] r2);
    req4 = r4;
    req2 = r2;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compares all visible outputs of the MAX_HOLD=4 instance.
  task automatic check4(input string tag, input logic [1:0] eSel, input logic [3:0] eGnt,
                        input logic eValid, input logic eY);
    checkOutput({tag, ".sel"},   8'(sel4),   8'(eSel));
    checkOutput({tag, ".gnt"},   8'(gnt4),   8'(eGnt));
    checkOutput({tag, ".valid"}, 8'(valid4), 8'(eValid));
    checkOutput({tag, ".y"},     8'(y4),     8'(eY));
  endtask

  initial begin
    logic [1:0] rotSel [9];
    logic [1:0] rs;
    rotSel = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    rst  = 1'b1;
    req4 = 4'b0000;
    x4   = 4'b1100;
    req2 = 4'b0000;
    x2   = 4'b1100;
    tick();
    tick();
    check4("reset", 2'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("reset.ptr",  8'(dut4.ptr_q), 8'd0);
    checkOutput("reset.hold", 8'(dut4.hold_cnt_q), 8'd0);
    rst = 1'b0;

    // Lone requester 2 runs into the hold limit repeatedly and is re-granted each time.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b0100, 4'b0000);
      check4("hold", 2'd2, 4'b0100, 1'b1, 1'b1);
      checkOutput("hold.cnt", 8'(dut4.hold_cnt_q), 8'(i % 4));
    end
    checkOutput("hold.ptr", 8'(dut4.ptr_q), 8'd3);

    // Sole requester drops: back to idle, sel keeps its last value.
    applyStimulus(4'b0000, 4'b0000);
    check4("idle", 2'd2, 4'b0000, 1'b0, 1'b0);
    checkOutput("idle.ptr", 8'(dut4.ptr_q), 8'd3);

    // Fairness across the wrap from requester 3 to requester 0.
    applyStimulus(4'b1000, 4'b0000);
    check4("wrap.g3", 2'd3, 4'b1000, 1'b1, 1'b1);
    applyStimulus(4'b0000, 4'b0000);
    check4("wrap.rel3", 2'd3, 4'b0000, 1'b0, 1'b0);
    checkOutput("wrap.ptr0", 8'(dut4.ptr_q), 8'd0);
    applyStimulus(4'b1001, 4'b0000);
    check4("wrap.g0", 2'd0, 4'b0001, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(4'b1001, 4'b0000);
      check4("wrap.keep0", 2'd0, 4'b0001, 1'b1, 1'b0);
      checkOutput("wrap.cnt0", 8'(dut4.hold_cnt_q), 8'(i));
    end
    applyStimulus(4'b1001, 4'b0000);
    check4("wrap.g3b", 2'd3, 4'b1000, 1'b1, 1'b1);
    checkOutput("wrap.ptr1", 8'(dut4.ptr_q), 8'd1);
    checkOutput("wrap.cnt3", 8'(dut4.hold_cnt_q), 8'd0);
    for (int i = 0; i < 3; i++) applyStimulus(4'b1001, 4'b0000);
    applyStimulus(4'b1001, 4'b0000);
    check4("wrap.g0b", 2'd0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4'b0000);
    check4("wrap.idle", 2'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("wrap.ptrIdle", 8'(dut4.ptr_q), 8'd1);

    // Reset in the middle of a grant to requester 2, with req still high.
    applyStimulus(4'b0100, 4'b0000);
    check4("rstmid.g2", 2'd2, 4'b0100, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    check4("rstmid.rst", 2'd0, 4'b0000, 1'b0, 1'b0);
    checkOutput("rstmid.ptr", 8'(dut4.ptr_q), 8'd0);
    rst = 1'b0;
    applyStimulus(4'b0100, 4'b0000);
    check4("rstmid.regrant", 2'd2, 4'b0100, 1'b1, 1'b1);

    rst = 1'b1;
    req4 = 4'b0000;
    tick();
    rst = 1'b0;

    // Early release: requester 0 drops after one held cycle, requester 1 takes over.
    applyStimulus(4'b0011, 4'b0000);
    check4("early.g0", 2'd0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0011, 4'b0000);
    check4("early.nopreempt", 2'd0, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0010, 4'b0000);
    check4("early.g1", 2'd1, 4'b0010, 1'b1, 1'b0);
    checkOutput("early.ptr", 8'(dut4.ptr_q), 8'd1);
    checkOutput("early.cnt", 8'(dut4.hold_cnt_q), 8'd0);
    applyStimulus(4'b0000, 4'b0000);

    // Full rotation on the MAX_HOLD=2 instance with every requester active.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b0000, 4'b1111);
      rs = rotSel[i];
      checkOutput("rot.sel",   8'(sel2),   8'(rs));
      checkOutput("rot.gnt",   8'(gnt2),   8'(4'b0001 << rs));
      checkOutput("rot.valid", 8'(valid2), 8'd1);
      checkOutput("rot.y",     8'(y2),     8'(rs >= 2'd2));
    end
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("rot.idleValid", 8'(valid2), 8'd0);
    checkOutput("rot.idleGnt",   8'(gnt2),   8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 4, maximum consecutive cycles one requester may hold the channel (legal range 1..8).
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 Port: req  input  4  request lines; req[i] high means requester i wants the shared channel.
REQ-005 Port: x  input  4  per-requester 1-bit data; x[i] belongs to requester i.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when no grant is active.
REQ-007 Port: sel  output  2  registered index of the granted requester; drives the 4:1 select.
REQ-008 Port: valid  output  1  registered; high while a grant is active.
REQ-009 Port: y  output  1  shared channel; combinational x[sel] when valid=1, else 0.

Function
REQ-010 FSM has two states only: IDLE and GRANT. All state lives in state, sel, gnt, valid, ptr[1:0] and hold_cnt.
REQ-011 Round-robin search order starts at ptr, then ptr+1, ptr+2, ptr+3, all mod 4. The winner is the first index in that order with req high.
REQ-012 IDLE, any req high: the next edge enters GRANT and sets sel to the winner, gnt to 1<<winner, valid to 1 and hold_cnt to 0. Grant latency is 1 cycle from req sampled high.
REQ-013 IDLE, req=0: the block stays in IDLE with valid=0 and gnt=0; sel and ptr hold their values.
REQ-014 GRANT: hold_cnt increments by 1 each cycle that the grant continues.
REQ-015 Release occurs on an edge where req[sel]=0, or where hold_cnt = MAX_HOLD-1. On every release, ptr is set to sel+1 mod 4.
REQ-016 On release, arbitration uses the updated ptr. With any req high, the block moves directly to the new winner with no idle bubble, and hold_cnt returns to 0.
REQ-017 On release with req=0, the block returns to IDLE with valid=0 and gnt=0.
REQ-018 A lone requester that reaches the hold limit and still requests is re-granted on the next cycle with hold_cnt=0. valid stays high through the re-grant.
REQ-019 Requests from non-granted requesters never pre-empt the current grant before release.
REQ-020 A requester that drops req and re-asserts it in the same cycle as its release is treated as a new request and is ordered by ptr.
REQ-021 gnt is always one-hot or zero. gnt[sel] equals valid at every cycle.
REQ-022 hold_cnt width is 3 bits and never exceeds MAX_HOLD-1.
REQ-023 With MAX_HOLD=1, the block releases on every cycle and rotates through all active requesters.

Reset
REQ-024 While rst=1 at an edge: state=IDLE, gnt=4'b0000, sel=2'd0, valid=0, ptr=2'd0, hold_cnt=0; y is therefore 0.
REQ-025 rst has priority over all other inputs. An active grant is abandoned on the reset edge.
REQ-026 After rst drops, requester 0 has top priority for the first arbitration.

Verification
REQ-027 Reset mid-grant: assert rst while sel=2 and valid=1 -> next cycle gnt=0000, valid=0, y=0; then req=0100 -> sel=2 one cycle later.
REQ-028 Single requester with hold limit: x=4'b1100, req=0100 held for 10 cycles, MAX_HOLD=4.
- Check: y=1 for the whole period and valid stays high.
- Check: hold_cnt cycles 0,1,2,3,0,...
REQ-029 Rotation: req=1111 constant, MAX_HOLD=2 -> sel sequence 0,0,1,1,2,2,3,3,0 with no valid gap.
- Check: y follows x[sel] with x=4'b1100.
REQ-030 Early release: req=0011; requester 0 drops req after 1 cycle of grant -> sel moves to 1 on the next edge and ptr becomes 1.
REQ-031 Fairness after wrap: grant requester 3 to release, then req=1001 -> requester 0 wins (ptr=0); repeat -> requester 3 wins.
REQ-032 Idle return: a sole requester drops req -> valid=0 and gnt=0000 on the next edge.
- Check: sel holds its last value and y=0.
